// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - two-flop synchronizer plus per-channel debounce with press/release pulses
// Optional auto-repeat of key_pressed is built when KEY_DEBOUNCER_AUTOREPEAT_EN is defined.
module key_debouncer #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ACTIVE_LOW      = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] key_raw,
   output logic [WIDTH-1:0] key_state,
   output logic [WIDTH-1:0] key_pressed,
   output logic [WIDTH-1:0] key_released
);
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("key_debouncer: invalid parameter values");
   end

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] sample;
   logic [WIDTH-1:0] accept;
   logic [CNT_W-1:0] cnt [WIDTH];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= INACTIVE;
         sync2 <= INACTIVE;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   // sample is 1 when the channel is active, whatever the pin polarity
   assign sample = sync2 ^ INACTIVE;

   always_comb begin
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = (sample[i] != key_state[i]) && (cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
         key_state    <= '0;
         key_released <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sample[i] == key_state[i] || accept[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         key_state    <= key_state ^ accept;
         key_released <= accept & key_state;
      end
   end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
   localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               RPT_W     = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt [WIDTH];
   logic [WIDTH-1:0] rpt_first;
   logic [WIDTH-1:0] rpt_fire;

   // an accepted change in the same cycle (i.e. a release) always wins over a repeat
   always_comb begin
      rpt_fire = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rpt_fire[i] = key_state[i] && !accept[i] &&
                       (rpt_cnt[i] == (rpt_first[i] ? RPT_FIRST : RPT_NEXT));
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WIDTH; i++) begin
            rpt_cnt[i] <= '0;
         end
         rpt_first   <= '0;
         key_pressed <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!key_state[i] || accept[i] || rpt_fire[i]) begin
               rpt_cnt[i] <= '0;
            end else begin
               rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
            end
            if (accept[i]) begin
               rpt_first[i] <= 1'b1;
            end else if (rpt_fire[i]) begin
               rpt_first[i] <= 1'b0;
            end
         end
         key_pressed <= (accept & ~key_state) | rpt_fire;
      end
   end
`else
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key_pressed <= '0;
      end else begin
         key_pressed <= accept & ~key_state;
      end
   end
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - directed and randomized self-checking bench for key_debouncer
module tb_key_debouncer;
   localparam int W  = 4;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic         clock   = 1'b0;
   logic         reset   = 1'b0;
   logic [W-1:0] key_raw = '1;
   logic [W-1:0] key_state;
   logic [W-1:0] key_pressed;
   logic [W-1:0] key_released;

   key_debouncer #(
      .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock), .reset(reset), .key_raw(key_raw),
      .key_state(key_state), .key_pressed(key_pressed), .key_released(key_released)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model: pin pipeline, window of recent samples, edges since last decision
   logic [W-1:0] m_s1, m_s2, m_state, m_pressed, m_released;
   logic [W-1:0] hist[$];
   int           n_since[W];
   int           since_press[W];

   int           edge_no;
   int           press_cnt[W], rel_cnt[W], first_press[W], first_rel[W], last_press[W];
   logic [W-1:0] vec_at5;
   int           press_edges[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_state = '0; m_pressed = '0; m_released = '0;
      hist.delete();
      for (int i = 0; i < W; i++) begin
         n_since[i] = 0;
         since_press[i] = -1;
      end
   endtask

   task automatic model_edge(input logic [W-1:0] raw);
      logic [W-1:0] samp;
      bit           stable;
      samp = ~m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      hist.push_back(samp);
      if (hist.size() > D) void'(hist.pop_front());
      m_pressed = '0;
      m_released = '0;
      for (int i = 0; i < W; i++) begin
         n_since[i]++;
         stable = (n_since[i] >= D);
         for (int k = 0; k < hist.size(); k++)
            if (hist[k][i] == m_state[i]) stable = 0;
         if (stable) begin
            m_state[i]     = ~m_state[i];
            m_pressed[i]   = m_state[i];
            m_released[i]  = ~m_state[i];
            n_since[i]     = 0;
            since_press[i] = m_state[i] ? 0 : -1;
         end else if (m_state[i]) begin
            since_press[i]++;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
            if (since_press[i] == RD || (since_press[i] > RD && (since_press[i] - RD) % RP == 0))
               m_pressed[i] = 1'b1;
`endif
         end
      end
   endtask

   task automatic clear_stats(input int start);
      edge_no = start;
      for (int i = 0; i < W; i++) begin
         press_cnt[i] = 0; rel_cnt[i] = 0;
         first_press[i] = -1; first_rel[i] = -1; last_press[i] = -1;
      end
      vec_at5 = '0;
      press_edges.delete();
   endtask

   task automatic check_outputs();
      chk("state", 32'(key_state), 32'(m_state));
      chk("pressed", 32'(key_pressed), 32'(m_pressed));
      chk("released", 32'(key_released), 32'(m_released));
   endtask

   task automatic tick();
      @(posedge clock);
      if (!reset) model_edge(key_raw);
      #1;
      check_outputs();
      for (int i = 0; i < W; i++) begin
         if (key_pressed[i] === 1'b1) begin
            press_cnt[i]++;
            last_press[i] = edge_no;
            if (first_press[i] < 0) first_press[i] = edge_no;
            if (i == 0) press_edges.push_back(edge_no);
         end
         if (key_released[i] === 1'b1) begin
            rel_cnt[i]++;
            if (first_rel[i] < 0) first_rel[i] = edge_no;
         end
      end
      if (edge_no == 5) vec_at5 = key_pressed;
      edge_no++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      clear_stats(0);
      model_reset();

      // reset asserted mid-cycle with all keys idle, held 20 cycles
      key_raw = '1;
      #3 reset = 1'b1;
      model_reset();
      #1 check_outputs();
      run(20);
      #4 reset = 1'b0;
      run(10);

      // clean press
      clear_stats(0);
      key_raw[0] = 1'b0;
      run(8);
      chk("press_edge", first_press[0], 5);
      chk("press_count", press_cnt[0], 1);
      chk("press_state", 32'(key_state[0]), 1);

      // clean release
      clear_stats(0);
      key_raw[0] = 1'b1;
      run(8);
      chk("release_edge", first_rel[0], 5);
      chk("release_count", rel_cnt[0], 1);

      // three-cycle glitch is rejected
      clear_stats(0);
      key_raw[0] = 1'b0;
      run(3);
      key_raw[0] = 1'b1;
      run(10);
      chk("glitch_press", press_cnt[0], 0);
      chk("glitch_release", rel_cnt[0], 0);
      chk("glitch_state", 32'(key_state[0]), 0);

      // bounce for 10 cycles, final transition before edge 10
      clear_stats(0);
      for (int s = 0; s < 10; s++) begin
         key_raw[0] = s[0];
         tick();
      end
      key_raw[0] = 1'b0;
      run(10);
      chk("bounce_press_edge", first_press[0], 15);
      chk("bounce_press_count", press_cnt[0], 1);
      clear_stats(0);
      key_raw[0] = 1'b1;
      run(8);
      chk("bounce_release_edge", first_rel[0], 5);
      chk("bounce_release_count", rel_cnt[0], 1);

      // all channels together
      clear_stats(0);
      key_raw = '0;
      run(8);
      chk("simul_vector", 32'(vec_at5), 32'hf);
      chk("simul_count", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 4);
      key_raw = '1;
      run(10);

      // randomized toggling on random channels
      clear_stats(0);
      repeat (600) begin
         if ($urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, W - 1);
            key_raw[idx] = ~key_raw[idx];
         end
         tick();
      end
      key_raw = '1;
      run(12);

      // reset while the count is in progress, key kept held
      clear_stats(0);
      key_raw[0] = 1'b0;
      run(4);
      #4 reset = 1'b1;
      model_reset();
      #1 check_outputs();
      run(2);
      #4 reset = 1'b0;
      clear_stats(1);
      run(8);
      chk("reset_mid_press_edge", first_press[0], 6);
      chk("reset_mid_press_count", press_cnt[0], 1);
      key_raw[0] = 1'b1;
      run(10);

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
      // held key repeats; release lands where a repeat would otherwise fire
      clear_stats(0);
      key_raw[0] = 1'b0;
      run(25);
      chk("repeat_count", press_cnt[0], 5);
      if (press_edges.size() >= 4) begin
         chk("repeat_p0", press_edges[0], 5);
         chk("repeat_p1", press_edges[1], 15);
         chk("repeat_p2", press_edges[2], 18);
         chk("repeat_p3", press_edges[3], 21);
      end else begin
         chk("repeat_edges_size", press_edges.size(), 4);
      end
      clear_stats(0);
      key_raw[0] = 1'b1;
      run(14);
      chk("repeat_release_edge", first_rel[0], 5);
      chk("repeat_release_count", rel_cnt[0], 1);
      chk("repeat_last_press", last_press[0], 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
